// File: rtl/layer_scroller_pkg.sv
// Shared constants, FSM encoding and row-generation helpers for the platform-row scroller and draw_layer.
// Latency: none (package only); backpressure: not applicable.
package layer_scroller_pkg;

  localparam int BLOCKS_N          = 7;
  localparam int BLOCK_WIDTH       = 80;
  localparam int BLOCK_HEIGHT      = 25;
  localparam int DEF_OFFSET_Y      = 100;
  localparam int DEF_SCREEN_HEIGHT = 600;
  localparam int YPOS_W            = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_GEN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef logic [BLOCKS_N-1:0] blk_row_t;

  typedef struct packed {
    blk_row_t layer_map;
    blk_row_t block_type;
    blk_row_t bonus_map;
  } row_t;

  // Column 0 sits in the MSB of each row so it lines up with draw_layer layer_map[0].
  localparam blk_row_t COL0_BIT     = 7'b1000000;
  localparam blk_row_t FALLBACK_MAP = 7'b0001000;
  localparam row_t RESET_ROW = '{layer_map: 7'h7F, block_type: 7'h7F, bonus_map: 7'h00};
  localparam row_t FIXED_ROW = '{layer_map: 7'b1010101, block_type: 7'b1100110, bonus_map: 7'b1000000};

  // Fibonacci LFSR, taps 16,14,13,11 (maximal length, never reaches zero from a nonzero seed).
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic row_t gen_row(input logic [15:0] lfsr);
    row_t       r;
    logic [2:0] col;
    col          = lfsr[15:13];
    r.layer_map  = (lfsr[6:0] == 7'd0) ? FALLBACK_MAP : lfsr[6:0];
    r.block_type = lfsr[13:7];
    r.bonus_map  = '0;
    if (lfsr[12:10] == 3'd0 && col != 3'd7)
      r.bonus_map = (COL0_BIT >> col) & r.layer_map;
    return r;
  endfunction

endpackage

// File: rtl/layer_scroller_lfsr16.sv
// 16-bit map-generator LFSR, loaded with seed on reset and advanced when en is high.
// Latency: one cycle per step; backpressure: none, en simply holds the state.
module lfsr16
  import layer_scroller_pkg::*;
(
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] lfsr
);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)
      lfsr <= seed;
    else if (en)
      lfsr <= lfsr_next(lfsr);
  end

endmodule

// File: rtl/layer_scroller.sv
// Platform-row scroller: per accepted frame_tick moves all rows down and regenerates rows leaving the screen (LAYER_FIXED_MAP_EN selects a fixed map).
// Latency: tick to settled outputs in 2 + wrapped rows cycles; backpressure: ticks while busy are dropped and flagged in sticky overrun.
module layer_scroller
  import layer_scroller_pkg::*;
#(
  parameter int          LAYERS        = 4,
  parameter int          LAYER_SPACING = 150,
  parameter int          SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int          OFFSET_Y      = DEF_OFFSET_Y,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                      pclk,
  input  logic                      rst_n,
  input  logic                      frame_tick,
  input  logic                      game_en,
  input  logic [3:0]                scroll_step,
  input  logic                      bonus_clear,
  input  logic [$clog2(LAYERS)-1:0] bonus_layer,
  input  logic [2:0]                bonus_col,
  output logic [7*LAYERS-1:0]       layer_map_flat,
  output logic [7*LAYERS-1:0]       block_type_flat,
  output logic [7*LAYERS-1:0]       bonus_map_flat,
  output logic [12*LAYERS-1:0]      ypos_flat,
  output logic                      recycle_pulse,
  output logic                      overrun
);

  localparam logic [YPOS_W-1:0] WRAP_AT  = YPOS_W'(SCREEN_HEIGHT + OFFSET_Y);
  localparam logic [YPOS_W-1:0] WRAP_SUB = YPOS_W'(LAYERS * LAYER_SPACING);

  state_t            state, state_nxt;
  logic [YPOS_W-1:0] ypos     [LAYERS];
  logic [YPOS_W-1:0] ypos_sum [LAYERS];
  row_t              rows     [LAYERS];
  logic [LAYERS-1:0] wrap;
  logic [LAYERS-1:0] wrap_hit;
  logic [LAYERS-1:0] gen_sel;
  row_t              new_row;

`ifdef LAYER_FIXED_MAP_EN
  always_comb new_row = FIXED_ROW;
`else
  logic [15:0] lfsr;

  lfsr16 u_lfsr (
    .pclk  (pclk),
    .rst_n (rst_n),
    .en    (state == ST_IDLE || state == ST_GEN),
    .seed  (LFSR_SEED),
    .lfsr  (lfsr)
  );

  always_comb new_row = gen_row(lfsr);
`endif

  always_comb begin
    for (int i = 0; i < LAYERS; i++) begin
      ypos_sum[i] = ypos[i] + {8'd0, scroll_step};
      wrap_hit[i] = (ypos_sum[i] >= WRAP_AT);
    end
    // Isolate the lowest pending row so GEN services rows in index order.
    gen_sel = wrap & (~wrap + LAYERS'(1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (frame_tick && game_en) state_nxt = ST_SCROLL;
      ST_SCROLL: state_nxt = (|wrap_hit) ? ST_GEN : ST_DONE;
      ST_GEN:    if ((wrap & ~gen_sel) == '0) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAYERS; i++) begin
        ypos[i] <= YPOS_W'(OFFSET_Y + i * LAYER_SPACING);
        rows[i] <= RESET_ROW;
      end
      wrap          <= '0;
      recycle_pulse <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      recycle_pulse <= 1'b0;
      if (frame_tick && state != ST_IDLE)
        overrun <= 1'b1;
      for (int i = 0; i < LAYERS; i++) begin
        if (bonus_clear && bonus_col != 3'd7 && int'(bonus_layer) == i)
          rows[i].bonus_map <= rows[i].bonus_map & ~(COL0_BIT >> bonus_col);
        if (state == ST_SCROLL) begin
          ypos[i] <= wrap_hit[i] ? (ypos_sum[i] - WRAP_SUB) : ypos_sum[i];
          wrap[i] <= wrap_hit[i];
        end
        // Placed after the bonus clear so a fresh row overrides a same-cycle clear.
        if (state == ST_GEN && gen_sel[i]) begin
          rows[i]       <= new_row;
          wrap[i]       <= 1'b0;
          recycle_pulse <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < LAYERS; g++) begin : g_flat
    assign layer_map_flat [7*g +: 7]       = rows[g].layer_map;
    assign block_type_flat[7*g +: 7]       = rows[g].block_type;
    assign bonus_map_flat [7*g +: 7]       = rows[g].bonus_map;
    assign ypos_flat      [12*g +: YPOS_W] = ypos[g];
  end

endmodule
